// File: rtl/home_input_conditioner.sv
// Input conditioner ahead of the living space controller: sync, debounce, button toggles, motion hold.
// Optional sensor_fault output and temperature gating under `SENSOR_FAULT_DETECT_EN.
module home_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES    = 1000000,
  parameter int unsigned MOTION_HOLD_CYCLES = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_mode_select,
  input  logic raw_motion,
  input  logic raw_smoke,
  input  logic raw_gas_leak,
  input  logic raw_door,
  input  logic raw_temp_high,
  input  logic raw_temp_low,
  input  logic raw_light_btn,
  input  logic raw_fan_btn,
  input  logic raw_ac_btn,
  input  logic raw_heating_btn,
  input  logic raw_cooling_btn,
`ifdef SENSOR_FAULT_DETECT_EN
  output logic sensor_fault,
`endif
  output logic clean_mode_select,
  output logic clean_motion,
  output logic clean_smoke,
  output logic clean_gas_leak,
  output logic clean_door,
  output logic clean_temp_high,
  output logic clean_temp_low,
  output logic light_req,
  output logic fan_req,
  output logic ac_req,
  output logic heating_req,
  output logic cooling_req
);

  localparam int unsigned NCH       = 12;
  localparam int unsigned NBTN      = 5;
  localparam int unsigned CW        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned CH_MODE   = 0;
  localparam int unsigned CH_MOTION = 1;
  localparam int unsigned CH_SMOKE  = 2;
  localparam int unsigned CH_GAS    = 3;
  localparam int unsigned CH_DOOR   = 4;
  localparam int unsigned CH_THIGH  = 5;
  localparam int unsigned CH_TLOW   = 6;
  localparam int unsigned CH_LIGHT  = 7;
  localparam int unsigned R_HEAT    = 3;
  localparam int unsigned R_COOL    = 4;

  localparam logic [NCH-1:0] HAZARD    = NCH'(12'b0000_0000_1100);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]    HOLD_LOAD = 32'(MOTION_HOLD_CYCLES);

  logic [NCH-1:0]  raw, sync1, sync2, stable, stable_nxt;
  logic [CW-1:0]   cnt     [NCH];
  logic [CW-1:0]   cnt_nxt [NCH];
  logic [NBTN-1:0] btn_d, rise, req, req_nxt;
  logic [31:0]     hold, hold_nxt;
  logic            motion_nxt;

  assign raw = {raw_cooling_btn, raw_heating_btn, raw_ac_btn, raw_fan_btn, raw_light_btn,
                raw_temp_low, raw_temp_high, raw_door, raw_gas_leak, raw_smoke,
                raw_motion, raw_mode_select};

  // Per-channel debounce; hazard channels accept a 1 straight from the first sync stage
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < NCH; i++) begin
      cnt_nxt[i] = '0;
      if (HAZARD[i] && sync1[i]) begin
        stable_nxt[i] = 1'b1;
      end else if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) stable_nxt[i] = sync2[i];
        else                    cnt_nxt[i]    = cnt[i] + CW'(1);
      end
    end
  end

  // Button toggles, gated by manual mode, with heating/cooling interlock
  assign rise = stable[CH_LIGHT +: NBTN] & ~btn_d;

  always_comb begin
    req_nxt = req;
    if (!(stable[CH_MODE] && stable_nxt[CH_MODE])) begin
      req_nxt = '0;
    end else begin
      req_nxt[2:0] = req[2:0] ^ rise[2:0];
      if (rise[R_HEAT] && !rise[R_COOL]) begin
        req_nxt[R_HEAT] = ~req[R_HEAT];
        if (!req[R_HEAT]) req_nxt[R_COOL] = 1'b0;
      end else if (rise[R_COOL] && !rise[R_HEAT]) begin
        req_nxt[R_COOL] = ~req[R_COOL];
        if (!req[R_COOL]) req_nxt[R_HEAT] = 1'b0;
      end
    end
  end

  // Occupancy hold after the debounced motion fall
  always_comb begin
    hold_nxt = hold;
    if (stable_nxt[CH_MOTION])  hold_nxt = '0;
    else if (stable[CH_MOTION]) hold_nxt = HOLD_LOAD;
    else if (hold != '0)        hold_nxt = hold - 32'd1;
    motion_nxt = stable_nxt[CH_MOTION] || (hold_nxt != '0);
  end

`ifdef SENSOR_FAULT_DETECT_EN
  logic fault_nxt;
  assign fault_nxt = sensor_fault | (stable_nxt[CH_THIGH] & stable_nxt[CH_TLOW]);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      stable       <= '0;
      btn_d        <= '0;
      req          <= '0;
      hold         <= '0;
      clean_motion <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
`ifdef SENSOR_FAULT_DETECT_EN
      sensor_fault    <= 1'b0;
      clean_temp_high <= 1'b0;
      clean_temp_low  <= 1'b0;
`endif
    end else begin
      sync1        <= raw;
      sync2        <= sync1;
      stable       <= stable_nxt;
      btn_d        <= stable[CH_LIGHT +: NBTN];
      req          <= req_nxt;
      hold         <= hold_nxt;
      clean_motion <= motion_nxt;
      for (int i = 0; i < NCH; i++) cnt[i] <= cnt_nxt[i];
`ifdef SENSOR_FAULT_DETECT_EN
      sensor_fault    <= fault_nxt;
      clean_temp_high <= stable_nxt[CH_THIGH] & ~fault_nxt;
      clean_temp_low  <= stable_nxt[CH_TLOW] & ~fault_nxt;
`endif
    end
  end

`ifndef SENSOR_FAULT_DETECT_EN
  assign clean_temp_high = stable[CH_THIGH];
  assign clean_temp_low  = stable[CH_TLOW];
`endif

  assign clean_mode_select = stable[CH_MODE];
  assign clean_smoke       = stable[CH_SMOKE];
  assign clean_gas_leak    = stable[CH_GAS];
  assign clean_door        = stable[CH_DOOR];
  assign light_req         = req[0];
  assign fan_req           = req[1];
  assign ac_req            = req[2];
  assign heating_req       = req[R_HEAT];
  assign cooling_req       = req[R_COOL];

endmodule

// File: tb/tb_home_input_conditioner.sv
// Bench for home_input_conditioner: window-based reference model checked every cycle plus literal spot checks.
module tb_home_input_conditioner;

  localparam int unsigned D   = 4;
  localparam int unsigned H   = 8;
  localparam int unsigned NCH = 12;

  logic clock;
  logic reset;
  logic raw_mode_select, raw_motion, raw_smoke, raw_gas_leak, raw_door, raw_temp_high, raw_temp_low;
  logic raw_light_btn, raw_fan_btn, raw_ac_btn, raw_heating_btn, raw_cooling_btn;
  logic clean_mode_select, clean_motion, clean_smoke, clean_gas_leak, clean_door;
  logic clean_temp_high, clean_temp_low;
  logic light_req, fan_req, ac_req, heating_req, cooling_req;
`ifdef SENSOR_FAULT_DETECT_EN
  logic sensor_fault;
`endif

  home_input_conditioner #(.DEBOUNCE_CYCLES(D), .MOTION_HOLD_CYCLES(H)) dut (
    .clock(clock), .reset(reset),
    .raw_mode_select(raw_mode_select), .raw_motion(raw_motion), .raw_smoke(raw_smoke),
    .raw_gas_leak(raw_gas_leak), .raw_door(raw_door), .raw_temp_high(raw_temp_high),
    .raw_temp_low(raw_temp_low), .raw_light_btn(raw_light_btn), .raw_fan_btn(raw_fan_btn),
    .raw_ac_btn(raw_ac_btn), .raw_heating_btn(raw_heating_btn), .raw_cooling_btn(raw_cooling_btn),
`ifdef SENSOR_FAULT_DETECT_EN
    .sensor_fault(sensor_fault),
`endif
    .clean_mode_select(clean_mode_select), .clean_motion(clean_motion), .clean_smoke(clean_smoke),
    .clean_gas_leak(clean_gas_leak), .clean_door(clean_door), .clean_temp_high(clean_temp_high),
    .clean_temp_low(clean_temp_low), .light_req(light_req), .fan_req(fan_req), .ac_req(ac_req),
    .heating_req(heating_req), .cooling_req(cooling_req)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bench-side channel order: 0 mode,1 motion,2 smoke,3 gas,4 door,5 th,6 tl,7 light,8 fan,9 ac,10 heat,11 cool
  logic [NCH-1:0] raw_v;
  assign raw_v = {raw_cooling_btn, raw_heating_btn, raw_ac_btn, raw_fan_btn, raw_light_btn,
                  raw_temp_low, raw_temp_high, raw_door, raw_gas_leak, raw_smoke,
                  raw_motion, raw_mode_select};

  logic [11:0] outs;
  assign outs = {clean_mode_select, clean_motion, clean_smoke, clean_gas_leak, clean_door,
                 clean_temp_high, clean_temp_low, light_req, fan_req, ac_req, heating_req, cooling_req};

  int checks = 0;
  int errors = 0;

  // Reference model: sh[c][j] is the raw value seen before edge (cyc-j)
  bit       sh [NCH][D+2];
  bit       ms [NCH];
  bit       ns [NCH];
  bit       mr [NCH];
  bit [4:0] mreq;
  bit       mfault;
  bit       started = 1'b0;
  int       cyc = 0;
  int       fall_edge = -1000000;

  always @(posedge clock) begin : model
    bit all_diff;
    bit h, c;
    cyc = cyc + 1;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int j = D + 1; j > 0; j--) sh[ch][j] = sh[ch][j-1];
      sh[ch][0] = raw_v[ch];
    end
    if (reset) begin
      started = 1'b1;
      for (int ch = 0; ch < NCH; ch++) begin
        sh[ch][0] = 1'b0;
        sh[ch][1] = 1'b0;
        ms[ch] = 1'b0;
        mr[ch] = 1'b0;
      end
      mreq = '0;
      mfault = 1'b0;
      fall_edge = -1000000;
    end else begin
      // stable flips once the synchronized input has disagreed for D consecutive edges
      for (int ch = 0; ch < NCH; ch++) begin
        ns[ch] = ms[ch];
        if ((ch == 2 || ch == 3) && sh[ch][1]) begin
          ns[ch] = 1'b1;
        end else begin
          all_diff = 1'b1;
          for (int j = 2; j < D + 2; j++) if (sh[ch][j] == ms[ch]) all_diff = 1'b0;
          if (all_diff) ns[ch] = !ms[ch];
        end
      end
      if (ms[0] && ns[0]) begin
        for (int b = 0; b < 3; b++) if (mr[7+b]) mreq[b] = !mreq[b];
        h = mr[10];
        c = mr[11];
        if (h && !c) begin
          mreq[3] = !mreq[3];
          if (mreq[3]) mreq[4] = 1'b0;
        end else if (c && !h) begin
          mreq[4] = !mreq[4];
          if (mreq[4]) mreq[3] = 1'b0;
        end
      end else begin
        mreq = '0;
      end
      if (ms[1] && !ns[1]) fall_edge = cyc;
      for (int ch = 0; ch < NCH; ch++) begin
        mr[ch] = ns[ch] && !ms[ch];
        ms[ch] = ns[ch];
      end
      if (ms[5] && ms[6]) mfault = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (started) begin
      chk("mode",   32'(clean_mode_select), 32'(ms[0]));
      chk("motion", 32'(clean_motion), 32'(ms[1] || ((cyc - fall_edge) < int'(H))));
      chk("smoke",  32'(clean_smoke), 32'(ms[2]));
      chk("gas",    32'(clean_gas_leak), 32'(ms[3]));
      chk("door",   32'(clean_door), 32'(ms[4]));
`ifdef SENSOR_FAULT_DETECT_EN
      chk("temp_high", 32'(clean_temp_high), 32'(ms[5] && !mfault));
      chk("temp_low",  32'(clean_temp_low), 32'(ms[6] && !mfault));
      chk("sensor_fault", 32'(sensor_fault), 32'(mfault));
`else
      chk("temp_high", 32'(clean_temp_high), 32'(ms[5]));
      chk("temp_low",  32'(clean_temp_low), 32'(ms[6]));
`endif
      chk("reqs", 32'({light_req, fan_req, ac_req, heating_req, cooling_req}),
          32'({mreq[0], mreq[1], mreq[2], mreq[3], mreq[4]}));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    {raw_mode_select, raw_motion, raw_smoke, raw_gas_leak, raw_door, raw_temp_high, raw_temp_low} = '1;
    {raw_light_btn, raw_fan_btn, raw_ac_btn, raw_heating_btn, raw_cooling_btn} = '1;
    at(1); chk("lit_reset_e1", 32'(outs), 32'd0);
    at(2); chk("lit_reset_e2", 32'(outs), 32'd0);
    at(3); chk("lit_reset_e3", 32'(outs), 32'd0);
    reset = 1'b0;
    {raw_mode_select, raw_motion, raw_smoke, raw_gas_leak, raw_door, raw_temp_high, raw_temp_low} = '0;
    {raw_light_btn, raw_fan_btn, raw_ac_btn, raw_heating_btn, raw_cooling_btn} = '0;
    at(4); chk("lit_post_reset", 32'(outs), 32'd0);

    at(9);  raw_door = 1'b1;
    at(14); chk("lit_door_e14", 32'(clean_door), 32'd0);
    at(15); chk("lit_door_e15", 32'(clean_door), 32'd1);

    at(19); raw_smoke = 1'b1;
    at(20); chk("lit_smoke_e20", 32'(clean_smoke), 32'd0);
    at(21); chk("lit_smoke_e21", 32'(clean_smoke), 32'd1);
    at(29); raw_smoke = 1'b0;
    at(34); chk("lit_smoke_e34", 32'(clean_smoke), 32'd1);
    at(35); chk("lit_smoke_e35", 32'(clean_smoke), 32'd0);

    at(39); raw_door = 1'b0;
    at(42); raw_door = 1'b1;
    at(48); chk("lit_door_glitch", 32'(clean_door), 32'd1);

    at(49); raw_mode_select = 1'b1;
    at(55); chk("lit_mode_on", 32'(clean_mode_select), 32'd1);

    at(59); raw_light_btn = 1'b1;
    at(65); raw_light_btn = 1'b0; chk("lit_light1_e65", 32'(light_req), 32'd0);
    at(66); chk("lit_light1_e66", 32'(light_req), 32'd1);
    at(79); raw_light_btn = 1'b1;
    at(85); raw_light_btn = 1'b0; chk("lit_light2_e85", 32'(light_req), 32'd1);
    at(86); chk("lit_light2_e86", 32'(light_req), 32'd0);
    at(99); raw_light_btn = 1'b1;
    at(105); raw_light_btn = 1'b0;
    at(106); chk("lit_light3", 32'(light_req), 32'd1);
    at(109); raw_mode_select = 1'b0;
    at(114); chk("lit_modefall_e114", 32'({clean_mode_select, light_req}), 32'b11);
    at(115); chk("lit_modefall_e115", 32'({clean_mode_select, light_req}), 32'b00);
    at(119); raw_light_btn = 1'b1;
    at(125); raw_light_btn = 1'b0;
    at(130); chk("lit_auto_press", 32'(light_req), 32'd0);

    at(139); raw_mode_select = 1'b1;
    at(149); raw_heating_btn = 1'b1;
    at(155); raw_heating_btn = 1'b0;
    at(156); chk("lit_heat_on", 32'({heating_req, cooling_req}), 32'b10);
    at(169); raw_cooling_btn = 1'b1;
    at(175); raw_cooling_btn = 1'b0; chk("lit_il_e175", 32'({heating_req, cooling_req}), 32'b10);
    at(176); chk("lit_il_e176", 32'({heating_req, cooling_req}), 32'b01);
    at(189); raw_heating_btn = 1'b1; raw_cooling_btn = 1'b1;
    at(195); raw_heating_btn = 1'b0; raw_cooling_btn = 1'b0;
    at(196); chk("lit_both", 32'({heating_req, cooling_req}), 32'b01);
    at(209); raw_fan_btn = 1'b1;
    at(215); raw_fan_btn = 1'b0;
    at(216); chk("lit_fan", 32'({fan_req, ac_req}), 32'b10);

    at(229); raw_motion = 1'b1;
    at(234); chk("lit_motion_e234", 32'(clean_motion), 32'd0);
    at(235); raw_motion = 1'b0; chk("lit_motion_e235", 32'(clean_motion), 32'd1);
    at(248); chk("lit_hold_e248", 32'(clean_motion), 32'd1);
    at(249); chk("lit_hold_e249", 32'(clean_motion), 32'd0);
    at(259); raw_motion = 1'b1;
    at(265); raw_motion = 1'b0;
    at(272); raw_motion = 1'b1;
    at(278); raw_motion = 1'b0;
    at(279); chk("lit_rehold_e279", 32'(clean_motion), 32'd1);
    at(291); chk("lit_rehold_e291", 32'(clean_motion), 32'd1);
    at(292); chk("lit_rehold_e292", 32'(clean_motion), 32'd0);

    at(299); raw_temp_high = 1'b1; raw_temp_low = 1'b1;
    at(304); chk("lit_temp_e304", 32'(clean_temp_high), 32'd0);
`ifdef SENSOR_FAULT_DETECT_EN
    at(305); chk("lit_temp_fault", 32'({clean_temp_high, clean_temp_low, sensor_fault}), 32'b001);
`else
    at(305); chk("lit_temp_e305", 32'({clean_temp_high, clean_temp_low}), 32'b11);
`endif

    at(309); raw_door = 1'b0;
    at(311); reset = 1'b1;
    at(312); reset = 1'b0; chk("lit_midreset", 32'(outs), 32'd0);
    at(317); chk("lit_restart_e317", 32'({clean_mode_select, clean_temp_high}), 32'b00);
`ifdef SENSOR_FAULT_DETECT_EN
    at(318); chk("lit_restart_e318", 32'({clean_mode_select, clean_temp_high}), 32'b10);
`else
    at(318); chk("lit_restart_e318", 32'({clean_mode_select, clean_temp_high}), 32'b11);
`endif
    at(325);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
